// File: rtl/page_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : page_sequencer_pkg
// Description : Shared page codes, game-result codes, VGA geometry, colours
//               and the page state type for the screen controller.
// Contents    : page_e     - page/state encoding (also drives page_sel)
//               page_pixel - selects the RGB565 pixel of the shown page
// Revision    : 1.0 - initial release
// ============================================================================
package page_sequencer_pkg;

   localparam logic [1:0]  PAGE_TITLE = 2'b00;
   localparam logic [1:0]  PAGE_PLAY  = 2'b01;
   localparam logic [1:0]  PAGE_END   = 2'b10;

   localparam logic        GAME_WON   = 1'b0;
   localparam logic        GAME_LSE   = 1'b1;

   localparam int          VGA_WIDTH  = 640;
   localparam int          VGA_HEIGHT = 480;

   localparam logic [15:0] BLACK      = 16'h0000;

   // The state encoding is the page code, so page_sel is the state register.
   typedef enum logic [1:0] {
      ST_TITLE = PAGE_TITLE,
      ST_PLAY  = PAGE_PLAY,
      ST_END   = PAGE_END
   } page_e;

   function automatic logic [15:0] page_pixel(
      input page_e       sel,
      input logic [15:0] pix_title,
      input logic [15:0] pix_play,
      input logic [15:0] pix_end
   );
      logic [15:0] pix;
      pix = BLACK;
      case (sel)
         ST_TITLE: pix = pix_title;
         ST_PLAY:  pix = pix_play;
         ST_END:   pix = pix_end;
         default:  pix = BLACK;
      endcase
      return pix;
   endfunction

endpackage
`default_nettype wire

// File: rtl/page_sequencer_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : page_sequencer_frame_timer
// Description : Frame-boundary detector, game-seconds counter and end-page
//               hold counter for the page sequencer.
// Ports       : clk_i, rst_i      - pixel clock, async active-high reset
//               pix_x_i, pix_y_i  - raster position
//               time_clr_i        - clear prescaler and game time
//               time_run_i        - count seconds (PLAY)
//               hold_run_i        - count hold frames (END); clears when low
//               frame_start_o     - registered pulse on entry to (0,0)
//               game_time_o       - saturating elapsed seconds
//               hold_done_o       - hold counter has reached END_HOLD_FRAMES
// Revision    : 1.0 - initial release
// ============================================================================
module page_sequencer_frame_timer #(
   parameter int FRAMES_PER_SEC  = 60,
   parameter int END_HOLD_FRAMES = 180,
   parameter int TIME_W          = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [9:0]        pix_x_i,
   input  logic [9:0]        pix_y_i,
   input  logic              time_clr_i,
   input  logic              time_run_i,
   input  logic              hold_run_i,
   output logic              frame_start_o,
   output logic [TIME_W-1:0] game_time_o,
   output logic              hold_done_o
);

   localparam int PRE_W  = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam int HOLD_W = (END_HOLD_FRAMES > 0) ? $clog2(END_HOLD_FRAMES + 1) : 1;
   localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(FRAMES_PER_SEC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(END_HOLD_FRAMES);
   localparam logic [TIME_W-1:0] TIME_MAX = '1;

   logic              w_origin;
   logic              origin_q;
   logic              frame_start_q;
   logic [PRE_W-1:0]  pre_q,  pre_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   assign w_origin = (pix_x_i == 10'd0) && (pix_y_i == 10'd0);

   always_comb begin
      pre_d  = pre_q;
      time_d = time_q;
      hold_d = hold_q;

      if (time_clr_i) begin
         pre_d  = '0;
         time_d = '0;
      end else if (time_run_i && frame_start_q) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (time_q != TIME_MAX) begin
               time_d = time_q + TIME_W'(1);
            end
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end

      // Hold count only lives while the end page is shown.
      if (!hold_run_i) begin
         hold_d = '0;
      end else if (frame_start_q && (hold_q != HOLD_MAX)) begin
         hold_d = hold_q + HOLD_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         origin_q      <= 1'b0;
         frame_start_q <= 1'b0;
         pre_q         <= '0;
         time_q        <= '0;
         hold_q        <= '0;
      end else begin
         // Edge detect so a raster parked at (0,0) yields one pulse only.
         origin_q      <= w_origin;
         frame_start_q <= w_origin && !origin_q;
         pre_q         <= pre_d;
         time_q        <= time_d;
         hold_q        <= hold_d;
      end
   end

   assign frame_start_o = frame_start_q;
   assign game_time_o   = time_q;
   assign hold_done_o   = (hold_q == HOLD_MAX);

endmodule
`default_nettype wire

// File: rtl/page_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : page_sequencer
// Description : Screen controller for the VGA game. Sequences TITLE, PLAY and
//               END pages on frame boundaries, muxes the shown page's pixel,
//               latches the game result and reports game time.
// Ports       : vga_clk, sys_rst          - pixel clock, async active-high reset
//               pix_x, pix_y              - raster position
//               start_btn                 - start/continue pulse
//               game_won, game_lost       - game-end pulses
//               score_in                  - live score
//               pix_data_title/play/end   - per-page RGB565 pixels
//               pix_data                  - registered selected pixel
//               page_sel, play_en         - current page, game enable
//               game_state, final_score   - latched result
//               game_time                 - elapsed play seconds
//               frame_start               - frame boundary pulse
// Revision    : 1.0 - initial release
// ============================================================================
module page_sequencer
   import page_sequencer_pkg::*;
#(
   parameter int H_VALID         = VGA_WIDTH,
   parameter int V_VALID         = VGA_HEIGHT,
   parameter int FRAMES_PER_SEC  = 60,
   parameter int END_HOLD_FRAMES = 180,
   parameter int SCORE_W         = 14,
   parameter int TIME_W          = 10
) (
   input  logic               vga_clk,
   input  logic               sys_rst,
   input  logic [9:0]         pix_x,
   input  logic [9:0]         pix_y,
   input  logic               start_btn,
   input  logic               game_won,
   input  logic               game_lost,
   input  logic [SCORE_W-1:0] score_in,
   input  logic [15:0]        pix_data_title,
   input  logic [15:0]        pix_data_play,
   input  logic [15:0]        pix_data_end,
   output logic [15:0]        pix_data,
   output logic [1:0]         page_sel,
   output logic               play_en,
   output logic               game_state,
   output logic [SCORE_W-1:0] final_score,
   output logic [TIME_W-1:0]  game_time,
   output logic               frame_start
);

   localparam logic [9:0] H_LIM = 10'(H_VALID);
   localparam logic [9:0] V_LIM = 10'(V_VALID);

   page_e              state_q;
   logic               pend_play_q;
   logic               pend_end_q;
   logic               pend_title_q;
   logic               play_en_q;
   logic               game_state_q;
   logic [SCORE_W-1:0] final_score_q;
   logic [15:0]        pix_data_q;

   logic               w_frame_start;
   logic               w_hold_done;
   logic               w_time_clr;

   // Pending flags are registered, so a request arriving on a frame_start
   // cycle can only be acted on at the following frame_start.
   assign w_time_clr = (state_q == ST_TITLE) && w_frame_start && pend_play_q;

   page_sequencer_frame_timer #(
      .FRAMES_PER_SEC  (FRAMES_PER_SEC),
      .END_HOLD_FRAMES (END_HOLD_FRAMES),
      .TIME_W          (TIME_W)
   ) u_frame_timer (
      .clk_i         (vga_clk),
      .rst_i         (sys_rst),
      .pix_x_i       (pix_x),
      .pix_y_i       (pix_y),
      .time_clr_i    (w_time_clr),
      .time_run_i    (state_q == ST_PLAY),
      .hold_run_i    (state_q == ST_END),
      .frame_start_o (w_frame_start),
      .game_time_o   (game_time),
      .hold_done_o   (w_hold_done)
   );

   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q       <= ST_TITLE;
         pend_play_q   <= 1'b0;
         pend_end_q    <= 1'b0;
         pend_title_q  <= 1'b0;
         play_en_q     <= 1'b0;
         game_state_q  <= GAME_WON;
         final_score_q <= '0;
      end else begin
         case (state_q)
            ST_TITLE: begin
               if (w_frame_start && pend_play_q) begin
                  state_q       <= ST_PLAY;
                  pend_play_q   <= 1'b0;
                  play_en_q     <= 1'b1;
                  game_state_q  <= GAME_WON;
                  final_score_q <= '0;
               end else if (start_btn) begin
                  pend_play_q <= 1'b1;
               end
            end
            ST_PLAY: begin
               if (w_frame_start && pend_end_q) begin
                  state_q    <= ST_END;
                  pend_end_q <= 1'b0;
                  play_en_q  <= 1'b0;
               end else if (!pend_end_q && (game_won || game_lost)) begin
                  // First result wins; pend_end blocks later pulses.
                  final_score_q <= score_in;
                  game_state_q  <= game_won ? GAME_WON : GAME_LSE;
                  pend_end_q    <= 1'b1;
                  play_en_q     <= 1'b0;
               end
            end
            ST_END: begin
               if (w_frame_start && pend_title_q) begin
                  state_q      <= ST_TITLE;
                  pend_title_q <= 1'b0;
               end else if (start_btn && w_hold_done) begin
                  pend_title_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_TITLE;
            end
         endcase
      end
   end

   // Registered mux; source follows the page registered before this cycle.
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pix_data_q <= BLACK;
      end else if ((pix_x >= H_LIM) || (pix_y >= V_LIM)) begin
         pix_data_q <= BLACK;
      end else begin
         pix_data_q <= page_pixel(state_q, pix_data_title, pix_data_play, pix_data_end);
      end
   end

   assign pix_data    = pix_data_q;
   assign page_sel    = state_q;
   assign play_en     = play_en_q;
   assign game_state  = game_state_q;
   assign final_score = final_score_q;
   assign frame_start = w_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_page_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_page_sequencer
// Description : Self-checking bench for page_sequencer: directed vector table,
//               hand-written multi-cycle sequences and a randomized run
//               compared against a frame-counting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_page_sequencer;

   localparam int FPS  = 60;
   localparam int HOLD = 4;
   localparam int TW   = 2;
   localparam int SW   = 14;
   localparam int TMAX = (1 << TW) - 1;

   logic          vga_clk = 1'b0;
   logic          sys_rst = 1'b1;
   logic [9:0]    pix_x = 10'd100;
   logic [9:0]    pix_y = 10'd200;
   logic          start_btn = 1'b0;
   logic          game_won = 1'b0;
   logic          game_lost = 1'b0;
   logic [SW-1:0] score_in = '0;
   logic [15:0]   pix_data_title = 16'h1111;
   logic [15:0]   pix_data_play  = 16'h2222;
   logic [15:0]   pix_data_end   = 16'hFFE0;
   logic [15:0]   pix_data;
   logic [1:0]    page_sel;
   logic          play_en;
   logic          game_state;
   logic [SW-1:0] final_score;
   logic [TW-1:0] game_time;
   logic          frame_start;

   int n_vec = 0;
   int n_err = 0;
   bit model_on = 1'b0;

   page_sequencer #(
      .H_VALID         (640),
      .V_VALID         (480),
      .FRAMES_PER_SEC  (FPS),
      .END_HOLD_FRAMES (HOLD),
      .SCORE_W         (SW),
      .TIME_W          (TW)
   ) dut (
      .vga_clk        (vga_clk),
      .sys_rst        (sys_rst),
      .pix_x          (pix_x),
      .pix_y          (pix_y),
      .start_btn      (start_btn),
      .game_won       (game_won),
      .game_lost      (game_lost),
      .score_in       (score_in),
      .pix_data_title (pix_data_title),
      .pix_data_play  (pix_data_play),
      .pix_data_end   (pix_data_end),
      .pix_data       (pix_data),
      .page_sel       (page_sel),
      .play_en        (play_en),
      .game_state     (game_state),
      .final_score    (final_score),
      .game_time      (game_time),
      .frame_start    (frame_start)
   );

   always #5 vga_clk = ~vga_clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   // ---------------------------------------------------------------------
   // Reference model: tracks pages, pending requests and raw frame counts;
   // game time is derived by division, the hold by a plain frame count.
   // ---------------------------------------------------------------------
   int   m_page, m_frames, m_hold, m_score;
   bit   m_pend_play, m_pend_end, m_pend_title, m_prev_org, m_fs, m_play_en, m_gs;
   int   m_pix;

   function automatic void model_reset();
      m_page = 0; m_frames = 0; m_hold = 0; m_score = 0; m_pix = 0;
      m_pend_play = 0; m_pend_end = 0; m_pend_title = 0;
      m_prev_org = 0; m_fs = 0; m_play_en = 0; m_gs = 0;
   endfunction

   function automatic void model_step();
      bit fs_now;
      bit org;
      int x;
      int y;
      fs_now = m_fs;
      x = int'(pix_x);
      y = int'(pix_y);
      org = (x == 0) && (y == 0);
      m_fs = org && !m_prev_org;
      m_prev_org = org;
      if (x >= 640 || y >= 480) m_pix = 0;
      else if (m_page == 0) m_pix = int'(pix_data_title);
      else if (m_page == 1) m_pix = int'(pix_data_play);
      else m_pix = int'(pix_data_end);

      if (m_page == 0) begin
         if (fs_now && m_pend_play) begin
            m_page = 1; m_pend_play = 0; m_play_en = 1;
            m_frames = 0; m_score = 0; m_gs = 0;
         end else if (start_btn) begin
            m_pend_play = 1;
         end
      end else if (m_page == 1) begin
         if (fs_now) m_frames++;
         if (fs_now && m_pend_end) begin
            m_page = 2; m_pend_end = 0; m_play_en = 0; m_hold = 0;
         end else if (!m_pend_end && (game_won || game_lost)) begin
            m_score = int'(score_in);
            m_gs = !game_won;
            m_pend_end = 1;
            m_play_en = 0;
         end
      end else begin
         if (fs_now && m_pend_title) begin
            m_page = 0; m_pend_title = 0;
         end else if (start_btn && m_hold >= HOLD) begin
            m_pend_title = 1;
         end
         if (fs_now) m_hold++;
      end
   endfunction

   function automatic void model_check();
      int t;
      t = m_frames / FPS;
      if (t > TMAX) t = TMAX;
      chk("rand page_sel",    32'(page_sel),    32'(m_page));
      chk("rand play_en",     32'(play_en),     32'(m_play_en));
      chk("rand frame_start", 32'(frame_start), 32'(m_fs));
      chk("rand pix_data",    32'(pix_data),    32'(m_pix));
      chk("rand final_score", 32'(final_score), 32'(m_score));
      chk("rand game_state",  32'(game_state),  32'(m_gs));
      chk("rand game_time",   32'(game_time),   32'(t));
   endfunction

   task automatic tick();
      @(posedge vga_clk);
      if (model_on) model_step();
      #1;
      if (model_on) model_check();
   endtask

   // One frame boundary: parks at (0,0) then leaves; the FSM acts on the
   // second cycle, where frame_start is visible. st2 drives start_btn there.
   task automatic frame(input bit st2);
      pix_x = 10'd0; pix_y = 10'd0;
      tick();
      pix_x = 10'd1; pix_y = 10'd1; start_btn = st2;
      tick();
      start_btn = 1'b0;
   endtask

   typedef struct {
      int x; int y; int st; int won; int lost; int score;
      int page; int pe; int fs; int pix; int fscore; int gs;
   } vec_t;

   vec_t tbl[13];

   initial begin
      //          x    y  st won lost score | page pe fs pix      fscore gs
      tbl[0]  = '{100, 200, 1, 0, 0,    0,    0,   0, 0, 'h1111,    0, 0};
      tbl[1]  = '{  0,   0, 0, 0, 0,    0,    0,   0, 1, 'h1111,    0, 0};
      tbl[2]  = '{  0,   0, 0, 0, 0,    0,    1,   1, 0, 'h1111,    0, 0};
      tbl[3]  = '{  5,   5, 0, 0, 0,    0,    1,   1, 0, 'h2222,    0, 0};
      tbl[4]  = '{700,  50, 0, 0, 0,    0,    1,   1, 0,      0,    0, 0};
      tbl[5]  = '{639, 479, 0, 0, 0,    0,    1,   1, 0, 'h2222,    0, 0};
      tbl[6]  = '{640,   0, 0, 0, 0,    0,    1,   1, 0,      0,    0, 0};
      tbl[7]  = '{  0, 480, 0, 0, 0,    0,    1,   1, 0,      0,    0, 0};
      tbl[8]  = '{ 10,  10, 0, 1, 1, 1234,    1,   0, 0, 'h2222, 1234, 0};
      tbl[9]  = '{  0,   0, 0, 0, 0,  999,    1,   0, 1, 'h2222, 1234, 0};
      tbl[10] = '{  1,   0, 0, 1, 0,  555,    2,   0, 0, 'h2222, 1234, 0};
      tbl[11] = '{ 50,  50, 0, 0, 0,  555,    2,   0, 0, 'hFFE0, 1234, 0};
      tbl[12] = '{700,  50, 0, 0, 0,  555,    2,   0, 0,      0, 1234, 0};

      // Reset state
      repeat (2) @(posedge vga_clk);
      #1;
      chk("reset page_sel",    32'(page_sel),    32'd0);
      chk("reset play_en",     32'(play_en),     32'd0);
      chk("reset pix_data",    32'(pix_data),    32'd0);
      chk("reset final_score", 32'(final_score), 32'd0);
      chk("reset game_state",  32'(game_state),  32'd0);
      chk("reset game_time",   32'(game_time),   32'd0);
      chk("reset frame_start", 32'(frame_start), 32'd0);
      sys_rst = 1'b0;

      // Directed vector table
      for (int i = 0; i < 13; i++) begin
         pix_x     = 10'(tbl[i].x);
         pix_y     = 10'(tbl[i].y);
         start_btn = (tbl[i].st != 0);
         game_won  = (tbl[i].won != 0);
         game_lost = (tbl[i].lost != 0);
         score_in  = SW'(tbl[i].score);
         tick();
         chk($sformatf("vec%0d page_sel", i),    32'(page_sel),    32'(tbl[i].page));
         chk($sformatf("vec%0d play_en", i),     32'(play_en),     32'(tbl[i].pe));
         chk($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'(tbl[i].fs));
         chk($sformatf("vec%0d pix_data", i),    32'(pix_data),    32'(tbl[i].pix));
         chk($sformatf("vec%0d final_score", i), 32'(final_score), 32'(tbl[i].fscore));
         chk($sformatf("vec%0d game_state", i),  32'(game_state),  32'(tbl[i].gs));
      end
      start_btn = 1'b0; game_won = 1'b0; game_lost = 1'b0;

      // END hold: start before the hold expires must be dropped
      frame(1'b0);
      frame(1'b0);
      pix_x = 10'd5; pix_y = 10'd5; start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      frame(1'b0);
      frame(1'b0);
      frame(1'b0);
      chk("early start ignored page_sel", 32'(page_sel), 32'd2);
      pix_x = 10'd5; pix_y = 10'd5; start_btn = 1'b1;
      tick();
      start_btn = 1'b0;
      chk("start waits for frame page_sel", 32'(page_sel), 32'd2);
      frame(1'b0);
      chk("end->title page_sel",    32'(page_sel),    32'd0);
      chk("title keeps final_score", 32'(final_score), 32'd1234);
      chk("title keeps game_state",  32'(game_state),  32'd0);

      // Start on the frame_start cycle itself transitions one frame later
      frame(1'b1);
      chk("same-cycle start page_sel", 32'(page_sel), 32'd0);
      frame(1'b0);
      chk("title->play page_sel",     32'(page_sel),    32'd1);
      chk("title->play play_en",      32'(play_en),     32'd1);
      chk("title->play final_score",  32'(final_score), 32'd0);
      chk("title->play game_time",    32'(game_time),   32'd0);

      // Game time: 150 frames -> 2 s, 300 frames -> saturates at 3
      repeat (150) frame(1'b0);
      chk("150 frames game_time", 32'(game_time), 32'd2);
      repeat (150) frame(1'b0);
      chk("300 frames game_time saturated", 32'(game_time), 32'(TMAX));

      // Asynchronous reset in PLAY
      pix_x = 10'd20; pix_y = 10'd20;
      #2 sys_rst = 1'b1;
      #1;
      chk("async rst page_sel",  32'(page_sel),  32'd0);
      chk("async rst game_time", 32'(game_time), 32'd0);
      chk("async rst pix_data",  32'(pix_data),  32'd0);
      chk("async rst play_en",   32'(play_en),   32'd0);
      @(posedge vga_clk);
      #1 sys_rst = 1'b0;
      tick();
      chk("after rst page_sel", 32'(page_sel), 32'd0);
      chk("after rst play_en",  32'(play_en),  32'd0);

      // Randomized run against the reference model
      sys_rst = 1'b1;
      tick();
      sys_rst = 1'b0;
      model_reset();
      model_on = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            pix_x = 10'd0; pix_y = 10'd0;
         end else begin
            pix_x = 10'($urandom_range(0, 799));
            pix_y = 10'($urandom_range(0, 524));
         end
         start_btn      = ($urandom_range(0, 15) == 0);
         game_won       = ($urandom_range(0, 799) == 0);
         game_lost      = ($urandom_range(0, 799) == 0);
         score_in       = SW'($urandom);
         pix_data_title = 16'($urandom);
         pix_data_play  = 16'($urandom);
         pix_data_end   = 16'($urandom);
         tick();
      end
      model_on = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/page_sequencer.md
Name: page_sequencer

Overview:
Top-level screen controller for the VGA game display. It sequences the title, play and end pages, and muxes the selected page's pixel stream onto the single pix_data output. It also latches the final score, counts game time in seconds, and supplies game_state, final_score and game_time to the end page. Page switches happen only on frame boundaries, so no frame is ever torn.

Parameters:
H_VALID, 640, active pixels per line
V_VALID, 480, active lines per frame
FRAMES_PER_SEC, 60, frames per game-time second
END_HOLD_FRAMES, 180, minimum frames the end page is held before start_btn is honoured
SCORE_W, 14, score width in bits
TIME_W, 10, game_time width in seconds

Ports:
vga_clk  in  1  pixel clock; the only clock
sys_rst  in  1  asynchronous, active-high reset
pix_x  in  10  current pixel column from the VGA controller
pix_y  in  10  current pixel row from the VGA controller
start_btn  in  1  debounced single-cycle start/continue pulse
game_won  in  1  single-cycle pulse from game logic
game_lost  in  1  single-cycle pulse from game logic
score_in  in  SCORE_W  live score
pix_data_title  in  16  RGB565 pixel from the title page
pix_data_play  in  16  RGB565 pixel from the play page
pix_data_end  in  16  RGB565 pixel from the end page
pix_data  out  16  selected RGB565 pixel
page_sel  out  2  page currently displayed: 00 title, 01 play, 10 end
play_en  out  1  high while in PLAY; enables game logic
game_state  out  1  0 = won, 1 = lost
final_score  out  SCORE_W  score latched at game end
game_time  out  TIME_W  elapsed play seconds
frame_start  out  1  one-cycle pulse on the first cycle where pix_x==0 and pix_y==0

Behaviour:
- Reset (asynchronous, active-high). Every output goes to zero and the FSM enters TITLE: page_sel=00, play_en=0, pix_data=0, game_state=0, final_score=0, game_time=0, frame_start=0. All pending flags and counters clear. Reset asserted mid-operation has the same effect from any state.
- frame_start is registered. It pulses for one cycle on the first cycle where (pix_x,pix_y)==(0,0), and does not re-pulse while the position stays at (0,0).
- FSM states: TITLE, PLAY, END. page_sel is the state encoding.
- TITLE: start_btn sets pend_play. On a frame_start cycle with pend_play set:
  - go to PLAY;
  - clear game_time, the seconds prescaler and pend_play.
- PLAY:
  - play_en=1.
  - Prescaler counts frame_start pulses 0..FRAMES_PER_SEC-1. On wrap, game_time increments, saturating at 2^TIME_W-1.
- Game-end latch. The first game_won or game_lost pulse in PLAY:
  - captures score_in to final_score in that same cycle;
  - sets game_state (game_won wins if both pulse together);
  - sets pend_end and drops play_en on the next cycle.
  - Later won/lost pulses are ignored until the next PLAY.
- PLAY to END: taken on the next frame_start with pend_end set. game_time freezes at entry to END.
- END:
  - Hold counter counts frame_start pulses, saturating at END_HOLD_FRAMES.
  - start_btn is ignored until the hold counter reaches END_HOLD_FRAMES. After that, start_btn sets pend_title.
  - On the next frame_start with pend_title set, go to TITLE.
  - final_score, game_state and game_time stay valid until the next TITLE→PLAY transition.
- won/lost pulses outside PLAY are ignored. start_btn in PLAY is ignored.
- Simultaneous request and frame_start in the same cycle: the request is latched; the transition happens at the following frame_start, never the same one.
- Pixel mux:
  - Output is registered, one-cycle latency from pix_x/pix_y and the page inputs.
  - Source is selected by page_sel as registered in the prior cycle.
  - pix_data=0 when pix_x>=H_VALID or pix_y>=V_VALID.
- There are no other outputs; nothing is combinational to an output.

Decomposition:
- Shared define.vh holds:
  - page codes PAGE_TITLE/PAGE_PLAY/PAGE_END;
  - GAME_WON=0, GAME_LSE=1;
  - VGA_WIDTH/VGA_HEIGHT;
  - colour constants (BLACK 16'h0000).
- One sub-module, frame_timer, contains the frame_start edge detector, the seconds prescaler with saturating game_time, and the END hold counter with its done flag. The FSM and pixel mux stay in page_sequencer.

Test Plan:
- Reset during PLAY with game_time=5 → next cycle page_sel=00, game_time=0, pix_data=0, play_en=0.
- start_btn at pix (100,200) in TITLE → page_sel stays 00 until the next (0,0); becomes 01 on the cycle after frame_start, with play_en=1.
- 150 frames in PLAY with FRAMES_PER_SEC=60 → game_time=2; with TIME_W=2 and 300 frames → game_time saturates at 3.
- game_won and game_lost in the same cycle with score_in=1234 → final_score=1234 and game_state=0; END entered at the next frame_start; a later score_in change does not alter final_score.
- END with END_HOLD_FRAMES=4: start_btn after 2 frames → stays END; start_btn after 4 frames → TITLE on the next frame_start.
- Drive pix_data_end=16'hFFE0 in END at pix (50,50) → pix_data=16'hFFE0 one cycle later; at pix (700,50) → pix_data=16'h0000.
